pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out and signed-overflow flags. The WIDTH-bit operation is split into STAGES equal carry chunks, one register stage per chunk, so wide adds meet timing. A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the datapath. It is the registered, width-generic successor of the team's 4-bit combinational ripple-carry adder.

---
 rtl/pipelined_addsub.sv | 163 ++++++++++++++++
 tb/tb_pipelined_addsub.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined two's-complement adder/subtractor. The WIDTH-bit operation is cut
// into STAGES equal carry chunks of CHUNK = WIDTH/STAGES bits. Stage k adds
// chunk k using the carry registered by stage k-1. The operands and the
// partial sum travel down the pipe with it. The whole pipe moves under one
// global enable, so a stalled output freezes every stage.
//
// Parameters
//   WIDTH   operand/result width (>= 1)
//   STAGES  pipeline depth and chunk count (1..WIDTH, divides WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears all state
//   in_valid   operand beat present
//   in_ready   pipe accepts a beat this cycle (= advance)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
// -----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  // Index k of each array is what enters stage k; index STAGES is the output
  // register of the last stage. Operands are not needed past the last stage.
  logic [WIDTH-1:0] a_pipe [STAGES];
  logic [WIDTH-1:0] b_pipe [STAGES];
  logic [WIDTH-1:0] s_pipe [STAGES+1];
  logic             c_pipe [STAGES+1];
  logic             v_pipe [STAGES+1];

  logic advance;

  // A stage may only overwrite its successor when the output slot is empty or
  // being drained; one enable for every stage keeps bubbles in their slots.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + 1; a borrow-in removes that +1 again.
  assign a_pipe[0] = a;
  assign b_pipe[0] = sub ? ~b : b;
  assign c_pipe[0] = cin ^ sub;
  assign v_pipe[0] = in_valid;
  assign s_pipe[0] = '0;

  assign out_valid = v_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;

    logic [CHUNK:0]   chunk_add;
    logic [WIDTH-1:0] s_merged;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] s_q;

    assign chunk_add = {1'b0, a_pipe[k][LO +: CHUNK]}
                     + {1'b0, b_pipe[k][LO +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_pipe[k]};

    // NOTE: the whole vector is assigned before the chunk is patched in, so
    // every bit has a value on every path and no latch is inferred.
    always_comb begin
      s_merged              = s_pipe[k];
      s_merged[LO +: CHUNK] = chunk_add[CHUNK-1:0];
    end

    // NOTE: state uses non-blocking assignments so all stages sample their
    // predecessors' old values on the same edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_pipe[k];
        c_q <= chunk_add[CHUNK];
        s_q <= s_merged;
      end
    end

    assign v_pipe[k+1] = v_q;
    assign c_pipe[k+1] = c_q;
    assign s_pipe[k+1] = s_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // NOTE: the operand registers are reset as well, not just the valid
      // bits, so no operand from a discarded beat survives a reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_pipe[k];
          b_q <= b_pipe[k];
        end
      end

      assign a_pipe[k+1] = a_q;
      assign b_pipe[k+1] = b_q;
    end else begin : g_ovf
      logic msb_cin;
      logic ovf_q;

      // Carry into the MSB: from the low CHUNK-1 bits of the last chunk, or,
      // with single-bit chunks, the carry handed over by the previous stage.
      if (CHUNK > 1) begin : g_inner
        logic [CHUNK-1:0] low_add;
        assign low_add = {1'b0, a_pipe[k][LO +: CHUNK-1]}
                       + {1'b0, b_pipe[k][LO +: CHUNK-1]}
                       + {{(CHUNK-1){1'b0}}, c_pipe[k]};
        assign msb_cin = low_add[CHUNK-1];
      end else begin : g_edge
        assign msb_cin = c_pipe[k];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= msb_cin ^ chunk_add[CHUNK];
        end
      end

      assign ovf = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//
// Directed vectors, backpressure and mid-flight reset on a 16/4 instance, then
// randomized streams with random backpressure on 8/1, 8/8 and 32/4 instances
// compared against an arithmetic reference model with an ordered scoreboard.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NR = 1000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    longint s;
    bit     co;
    bit     ov;
    int     cyc;
    int     stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   sweep_go = 1'b0;

  always #5 clk = ~clk;

  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic void ref_addsub(input int w, input longint ua, input longint ub,
                                     input bit ci, input bit is_sub,
                                     output longint s, output bit co, output bit ov);
    longint m    = longint'(1) << w;
    longint half = m / 2;
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sbv  = (ub >= half) ? ub - m : ub;
    longint t;
    longint r;
    if (!is_sub) begin
      t  = ua + ub + longint'(ci);
      co = (t >= m);
      r  = sa + sbv + longint'(ci);
    end else begin
      t  = ua - ub - longint'(ci);
      co = (t >= 0);
      r  = sa - sbv - longint'(ci);
    end
    s  = (t < 0) ? t + m : ((t >= m) ? t - m : t);
    ov = (r < -half) || (r >= half);
  endfunction

  // Caller is just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    bit seen = 1'b0;
    int lat  = 0;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_sum"}, sum, v.s);
    check({tag, "_cout"}, cout, v.co);
    check({tag, "_ovf"}, ovf, v.ov);
    @(posedge clk); #1;
  endtask

  task automatic backpressure();
    int next_i = 1;
    int exp_k  = 1;
    int hold   = 0;
    int cyc    = 0;
    bit hold_started = 1'b0;
    cin = 1'b0; sub = 1'b0;
    while (exp_k <= 8 && cyc < 100) begin
      in_valid = (next_i <= 8);
      a = W'(next_i);
      b = W'(next_i);
      if (!hold_started && out_valid) begin
        hold_started = 1'b1;
        hold = 3;
      end
      out_ready = (hold == 0);
      @(negedge clk);
      cyc++;
      if (hold > 0) begin
        check("bp_in_ready_hold", in_ready, 0);
        check("bp_valid_hold", out_valid, 1);
        check("bp_sum_stable", sum, 2);
        hold--;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_order_%0d", exp_k), sum, 2 * exp_k);
        exp_k++;
      end
      if (in_valid && in_ready) next_i++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_all_results", exp_k, 9);
  endtask

  task automatic reset_midflight();
    vec_t v;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = W'(16'h0100 + i); b = 16'h0011; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check("rm_accept", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rm_valid_before", out_valid, 1);
    check("rm_stalled_before", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("rm_valid_cleared", out_valid, 0);
    check("rm_sum_cleared", sum, 0);
    check("rm_in_ready_in_reset", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rm_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    v = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    run_vec(v, "rm_after");
  endtask

  // ---------------------------------------------------------------------------
  // Randomized parameter sweep.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 32 : 8;
    localparam int SS = (g == 0) ? 1 : ((g == 1) ? 8 : 4);

    logic          s_iv, s_ir, s_ci, s_sb, s_ov, s_ordy, s_co, s_of;
    logic [SW-1:0] s_a, s_b, s_sum;
    bit            done = 1'b0;

    pipelined_addsub #(.WIDTH(SW), .STAGES(SS)) dut_sw (
      .clk(clk), .rst(rst),
      .in_valid(s_iv), .in_ready(s_ir),
      .a(s_a), .b(s_b), .cin(s_ci), .sub(s_sb),
      .out_valid(s_ov), .out_ready(s_ordy),
      .sum(s_sum), .cout(s_co), .ovf(s_of)
    );

    initial begin
      exp_t   q[$];
      exp_t   e;
      longint rs;
      bit     rc;
      bit     ro;
      int     sent   = 0;
      int     got    = 0;
      int     cyc    = 0;
      int     stalls = 0;
      s_iv = 1'b0; s_ordy = 1'b1; s_a = '0; s_b = '0; s_ci = 1'b0; s_sb = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      while (got < NR && cyc < 20000) begin
        s_iv   = (sent < NR) && ($urandom_range(3) != 0);
        s_a    = SW'($urandom);
        s_b    = SW'($urandom);
        s_ci   = 1'($urandom_range(1));
        s_sb   = 1'($urandom_range(1));
        s_ordy = ($urandom_range(9) < 7);
        @(negedge clk);
        cyc++;
        check($sformatf("sw%0d_in_ready", g), s_ir, !s_ov || s_ordy);
        if (s_ov && s_ordy) begin
          if (q.size() == 0) begin
            check($sformatf("sw%0d_unexpected_out", g), 1, 0);
          end else begin
            e = q.pop_front();
            check($sformatf("sw%0d_sum", g), s_sum, e.s);
            check($sformatf("sw%0d_cout", g), s_co, e.co);
            check($sformatf("sw%0d_ovf", g), s_of, e.ov);
            check($sformatf("sw%0d_latency", g), cyc - e.cyc, SS + (stalls - e.stalls));
          end
          got++;
        end
        if (s_iv && s_ir) begin
          ref_addsub(SW, longint'(s_a), longint'(s_b), s_ci, s_sb, rs, rc, ro);
          q.push_back('{rs, rc, ro, cyc, stalls});
          sent++;
        end
        if (s_ov && !s_ordy) stalls++;
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      check($sformatf("sw%0d_results", g), got, NR);
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence.
  // ---------------------------------------------------------------------------
  initial begin
    vec_t vecs[8];
    bit   all_done = 1'b0;

    vecs[0] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    backpressure();
    reset_midflight();

    sweep_go = 1'b1;
    for (int t = 0; t < 30000 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
    end
    check("sweep_completed", all_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
